apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: PCLK clocks all state; PRESET is sampled on the PCLK rising edge only.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, range 1..255: number of consecutive ACCESS cycles with PREADY=0 before abort (used only with APB_MASTER_TIMEOUT_EN).
REQ-003 PCLK  in  1  system clock.
REQ-004 PRESET  in  1  synchronous active-high reset.
REQ-005 cmd_valid  in  1  command request; cmd_ready  out  1  command accept.
REQ-006 cmd_write  in  1  1=write, 0=read; cmd_addr  in  1  register select; cmd_wdata  in  16  write data; cmd_strb  in  2  byte strobes; cmd_prot  in  3  protection.
REQ-007 rsp_valid  out  1  one-cycle response pulse; rsp_rdata  out  16  read data; rsp_err  out  1  slave error or timeout.
REQ-008 PSEL0, PENABLE, PWRITE  out  1 each; PADDR  out  1; PWDATA  out  16; PPROT  out  3; PSTRB  out  2.
REQ-009 PRDATA  in  16; PREADY  in  1; PSLVERR  in  1.

Function
REQ-010 The FSM SHALL have states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid=1 and cmd_ready=1.
REQ-012 On acceptance, the FSM SHALL go to SETUP; in SETUP, PSEL0=1 and PENABLE=0.
REQ-013 On acceptance, PADDR, PWRITE, PPROT and PSTRB SHALL be latched from the command; PWDATA SHALL be latched from cmd_wdata.
REQ-014 On reads, PWDATA and PSTRB SHALL be driven 0.
REQ-015 All latched APB outputs SHALL remain stable from SETUP through the last ACCESS cycle.
REQ-016 SETUP SHALL always last exactly one cycle, then go to ACCESS with PSEL0=1 and PENABLE=1.
REQ-017 In ACCESS with PREADY=0, the FSM SHALL stay in ACCESS; wait states are unlimited unless the timeout is enabled.
REQ-018 In ACCESS with PREADY=1, the FSM SHALL capture PSLVERR into rsp_err.
REQ-019 On the same completing edge, rsp_rdata SHALL take PRDATA for reads and 0 for writes.
REQ-020 On the same completing edge, the FSM SHALL return to IDLE with PSEL0=0, PENABLE=0 and rsp_valid=1 for exactly one cycle.
REQ-021 Minimum transfer period is 3 cycles: accept at N, SETUP at N+1, ACCESS at N+2, IDLE/rsp_valid at N+3; a new command may be accepted at N+3.
REQ-022 rsp_rdata and rsp_err SHALL hold their values until the next response.
REQ-023 cmd_* inputs SHALL be ignored outside IDLE.
REQ-024 PRDATA and PSLVERR SHALL be ignored unless state is ACCESS and PREADY=1.

Reset
REQ-025 While PRESET=1 at an edge, the FSM SHALL enter IDLE.
REQ-026 Reset values: PSEL0=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PPROT=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0.
REQ-027 cmd_ready SHALL go to 1 on the first edge after PRESET deasserts.
REQ-028 Reset mid-transfer SHALL abort the transfer with no rsp_valid pulse, and the timeout counter SHALL clear.

Configuration
REQ-029 With APB_MASTER_TIMEOUT_EN defined, an 8-bit counter SHALL count consecutive ACCESS cycles with PREADY=0.
REQ-030 The counter SHALL clear on entry to ACCESS and on completion.
REQ-031 When the count reaches TIMEOUT_CYCLES, the FSM SHALL abort to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL0=0 and PENABLE=0.
REQ-032 Without APB_MASTER_TIMEOUT_EN, no counter SHALL be present and ACCESS SHALL wait indefinitely for PREADY.

Verification
REQ-033 Write addr=1, wdata=0xA5C3, strb=2'b11, PREADY=1 -> PSEL0 at N+1, PENABLE at N+2, PWDATA=0xA5C3, rsp_valid at N+3 with rsp_err=0.
REQ-034 Read addr=0, slave holds PREADY=0 for 3 ACCESS cycles then returns PRDATA=0x1234 -> rsp_rdata=0x1234 at N+6; PADDR/PWRITE stable throughout.
REQ-035 Read with PREADY=1, PSLVERR=1 -> rsp_err=1; PSTRB=0 and PWDATA=0 during the transfer.
REQ-036 Back-to-back commands with cmd_valid held high -> second SETUP at N+4; cmd_ready=0 during N+1..N+2.
REQ-037 PRESET=1 asserted during ACCESS -> PSEL0=0 and PENABLE=0 next cycle, no rsp_valid.
REQ-038 With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck at 0 -> abort after 4 ACCESS cycles with rsp_err=1, rsp_rdata=0; without the macro, still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_master.sv
// APB master bridging a simple command/response port onto one APB slave (PSEL0).
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic [1:0]  cmd_strb,
    input  logic [2:0]  cmd_prot,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        PSEL0,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic        PADDR,
    output logic [15:0] PWDATA,
    output logic [2:0]  PPROT,
    output logic [1:0]  PSTRB,
    input  logic [15:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t      state_reg, state_next;
    logic        cmd_ready_reg, cmd_ready_next;
    logic        psel_reg, psel_next;
    logic        penable_reg, penable_next;
    logic        pwrite_reg, pwrite_next;
    logic        paddr_reg, paddr_next;
    logic [15:0] pwdata_reg, pwdata_next;
    logic [2:0]  pprot_reg, pprot_next;
    logic [1:0]  pstrb_reg, pstrb_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [15:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg, rsp_err_next;

`ifdef APB_MASTER_TIMEOUT_EN
    // Abort fires on the edge that ends the TIMEOUT_CYCLES-th consecutive wait state.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_reg, tmo_cnt_next;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^8'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_next     = state_reg;
        cmd_ready_next = cmd_ready_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        pwrite_next    = pwrite_reg;
        paddr_next     = paddr_reg;
        pwdata_next    = pwdata_reg;
        pprot_next     = pprot_reg;
        pstrb_next     = pstrb_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_next   = tmo_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                cmd_ready_next = 1'b1;
                if (cmd_valid && cmd_ready_reg) begin
                    state_next     = SETUP;
                    cmd_ready_next = 1'b0;
                    psel_next      = 1'b1;
                    penable_next   = 1'b0;
                    pwrite_next    = cmd_write;
                    paddr_next     = cmd_addr;
                    pprot_next     = cmd_prot;
                    pwdata_next    = cmd_write ? cmd_wdata : 16'h0000;
                    pstrb_next     = cmd_write ? cmd_strb : 2'b00;
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                penable_next = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                tmo_cnt_next = 8'd0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    state_next     = IDLE;
                    cmd_ready_next = 1'b1;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = PSLVERR;
                    rsp_rdata_next = pwrite_reg ? 16'h0000 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_cnt_next   = 8'd0;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    state_next     = IDLE;
                    cmd_ready_next = 1'b1;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = 16'h0000;
                    tmo_cnt_next   = 8'd0;
                end else begin
                    tmo_cnt_next   = tmo_cnt_reg + 8'd1;
`endif
                end
            end
            default: begin
                state_next     = IDLE;
                cmd_ready_next = 1'b0;
                psel_next      = 1'b0;
                penable_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= 1'b0;
            pwdata_reg    <= 16'h0000;
            pprot_reg     <= 3'b000;
            pstrb_reg     <= 2'b00;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 16'h0000;
            rsp_err_reg   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_reg   <= 8'd0;
`endif
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            paddr_reg     <= paddr_next;
            pwdata_reg    <= pwdata_next;
            pprot_reg     <= pprot_next;
            pstrb_reg     <= pstrb_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_reg   <= tmo_cnt_next;
`endif
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign PSEL0     = psel_reg;
    assign PENABLE   = penable_reg;
    assign PWRITE    = pwrite_reg;
    assign PADDR     = paddr_reg;
    assign PWDATA    = pwdata_reg;
    assign PPROT     = pprot_reg;
    assign PSTRB     = pstrb_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_apb_master;
    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_addr = 1'b0;
    logic [15:0] cmd_wdata = '0;
    logic [1:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic [15:0] PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err, PSEL0, PENABLE, PWRITE, PADDR;
    logic [15:0] rsp_rdata, PWDATA;
    logic [2:0]  PPROT;
    logic [1:0]  PSTRB;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL0(PSEL0), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PPROT(PPROT), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a transfer is either absent or has an age
    // (1 = setup cycle, >=2 = access) and a count of wait states seen so far.
    bit          m_busy = 0;
    int          m_age = 0, m_waits = 0;
    logic        m_cmd_ready = 0, m_psel = 0, m_penable = 0, m_pwrite = 0, m_paddr = 0;
    logic        m_rsp_valid = 0, m_rsp_err = 0;
    logic [15:0] m_pwdata = 0, m_rsp_rdata = 0;
    logic [2:0]  m_pprot = 0;
    logic [1:0]  m_pstrb = 0;

    always @(posedge PCLK) begin
        if (PRESET) begin
            m_busy <= 0; m_age <= 0; m_waits <= 0;
            m_cmd_ready <= 0; m_psel <= 0; m_penable <= 0; m_pwrite <= 0; m_paddr <= 0;
            m_pwdata <= 0; m_pprot <= 0; m_pstrb <= 0;
            m_rsp_valid <= 0; m_rsp_rdata <= 0; m_rsp_err <= 0;
        end else begin
            m_rsp_valid <= 0;
            if (!m_busy) begin
                m_cmd_ready <= 1;
                if (cmd_valid && m_cmd_ready) begin
                    m_busy <= 1; m_age <= 1; m_cmd_ready <= 0;
                    m_psel <= 1; m_penable <= 0;
                    m_paddr <= cmd_addr; m_pwrite <= cmd_write; m_pprot <= cmd_prot;
                    m_pwdata <= cmd_write ? cmd_wdata : 16'h0;
                    m_pstrb <= cmd_write ? cmd_strb : 2'b0;
                end
            end else if (m_age == 1) begin
                m_age <= 2; m_penable <= 1; m_waits <= 0;
            end else if (PREADY) begin
                m_busy <= 0; m_cmd_ready <= 1; m_psel <= 0; m_penable <= 0;
                m_rsp_valid <= 1; m_rsp_err <= PSLVERR;
                m_rsp_rdata <= m_pwrite ? 16'h0 : PRDATA;
            end else begin
                m_waits <= m_waits + 1;
`ifdef APB_MASTER_TIMEOUT_EN
                if (m_waits + 1 == TO) begin
                    m_busy <= 0; m_cmd_ready <= 1; m_psel <= 0; m_penable <= 0;
                    m_rsp_valid <= 1; m_rsp_err <= 1; m_rsp_rdata <= 16'h0;
                end
`endif
            end
        end
    end

    always @(negedge PCLK) begin
        if (chk_en) begin
            check("m_cmd_ready", 16'(cmd_ready), 16'(m_cmd_ready));
            check("m_psel", 16'(PSEL0), 16'(m_psel));
            check("m_penable", 16'(PENABLE), 16'(m_penable));
            check("m_pwrite", 16'(PWRITE), 16'(m_pwrite));
            check("m_paddr", 16'(PADDR), 16'(m_paddr));
            check("m_pwdata", PWDATA, m_pwdata);
            check("m_pprot", 16'(PPROT), 16'(m_pprot));
            check("m_pstrb", 16'(PSTRB), 16'(m_pstrb));
            check("m_rsp_valid", 16'(rsp_valid), 16'(m_rsp_valid));
            check("m_rsp_rdata", rsp_rdata, m_rsp_rdata);
            check("m_rsp_err", 16'(rsp_err), 16'(m_rsp_err));
        end
    end

    task automatic drive_cmd(input logic w, input logic a, input logic [15:0] wd,
                             input logic [1:0] st, input logic [2:0] pr);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
    endtask

    task automatic nxt();
        @(negedge PCLK);
    endtask

    initial begin
        @(posedge PCLK);
        chk_en = 1'b1;
        repeat (2) nxt();
        check("rst_psel", 16'(PSEL0), 16'd0);
        check("rst_cmd_ready", 16'(cmd_ready), 16'd0);
        check("rst_pwdata", PWDATA, 16'h0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        PRESET = 0;
        nxt();
        check("cmd_ready_after_rst", 16'(cmd_ready), 16'd1);

        // Single write, zero wait states
        drive_cmd(1, 1, 16'hA5C3, 2'b11, 3'b010); PREADY = 1; PSLVERR = 0; PRDATA = 16'hDEAD;
        nxt();
        check("wr_setup_psel", 16'(PSEL0), 16'd1);
        check("wr_setup_penable", 16'(PENABLE), 16'd0);
        check("wr_pwdata", PWDATA, 16'hA5C3);
        check("wr_pstrb", 16'(PSTRB), 16'd3);
        check("wr_paddr", 16'(PADDR), 16'd1);
        cmd_valid = 0;
        nxt();
        check("wr_access_penable", 16'(PENABLE), 16'd1);
        check("wr_access_cmd_ready", 16'(cmd_ready), 16'd0);
        nxt();
        check("wr_rsp_valid", 16'(rsp_valid), 16'd1);
        check("wr_rsp_err", 16'(rsp_err), 16'd0);
        check("wr_rsp_rdata", rsp_rdata, 16'h0);
        check("wr_done_psel", 16'(PSEL0), 16'd0);

        // Read with three wait states
        drive_cmd(0, 0, 16'h7777, 2'b11, 3'b001); PREADY = 0;
        nxt();
        check("rd_pwdata_zero", PWDATA, 16'h0);
        cmd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            nxt();
            check("rd_wait_penable", 16'(PENABLE), 16'd1);
            check("rd_wait_pwrite", 16'(PWRITE), 16'd0);
            check("rd_wait_rsp_valid", 16'(rsp_valid), 16'd0);
            PRDATA = 16'($urandom); PSLVERR = 1;
        end
        nxt();
        PREADY = 1; PRDATA = 16'h1234; PSLVERR = 0;
        nxt();
        check("rd_rsp_valid", 16'(rsp_valid), 16'd1);
        check("rd_rsp_rdata", rsp_rdata, 16'h1234);

        // Read with slave error
        drive_cmd(0, 1, 16'hFFFF, 2'b11, 3'b111); PREADY = 1; PSLVERR = 1; PRDATA = 16'h5A5A;
        nxt();
        check("err_pstrb_zero", 16'(PSTRB), 16'd0);
        check("err_pwdata_zero", PWDATA, 16'h0);
        check("err_pprot", 16'(PPROT), 16'd7);
        cmd_valid = 0;
        nxt();
        nxt();
        check("err_rsp_err", 16'(rsp_err), 16'd1);
        check("err_rsp_rdata", rsp_rdata, 16'h5A5A);
        PSLVERR = 0;
        nxt();
        check("hold_rsp_valid", 16'(rsp_valid), 16'd0);
        check("hold_rsp_err", 16'(rsp_err), 16'd1);

        // Back-to-back writes with cmd_valid held
        drive_cmd(1, 0, 16'h1111, 2'b01, 3'b000); PREADY = 1;
        nxt();
        check("b2b_cmd_ready_n1", 16'(cmd_ready), 16'd0);
        cmd_wdata = 16'h2222; cmd_strb = 2'b10;
        nxt();
        check("b2b_cmd_ready_n2", 16'(cmd_ready), 16'd0);
        check("b2b_pwdata_stable", PWDATA, 16'h1111);
        nxt();
        check("b2b_rsp_valid", 16'(rsp_valid), 16'd1);
        nxt();
        check("b2b_second_setup", 16'({PSEL0, PENABLE}), 16'b10);
        check("b2b_second_pwdata", PWDATA, 16'h2222);
        cmd_valid = 0;
        repeat (2) nxt();

        // Reset during ACCESS
        drive_cmd(0, 1, 16'h0, 2'b00, 3'b000); PREADY = 0;
        nxt();
        cmd_valid = 0;
        nxt();
        check("rst_mid_access", 16'(PENABLE), 16'd1);
        PRESET = 1;
        nxt();
        check("rst_mid_psel", 16'({PSEL0, PENABLE}), 16'b00);
        check("rst_mid_rsp_valid", 16'(rsp_valid), 16'd0);
        PRESET = 0;
        nxt();
        check("rst_mid_ready", 16'(cmd_ready), 16'd1);

        // Stuck slave
        drive_cmd(0, 0, 16'h0, 2'b00, 3'b000); PREADY = 0; PRDATA = 16'hCAFE;
        nxt();
        cmd_valid = 0;
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            nxt();
            check("tmo_waiting", 16'({PSEL0, PENABLE, rsp_valid}), 16'b110);
        end
        nxt();
        check("tmo_rsp_valid", 16'(rsp_valid), 16'd1);
        check("tmo_rsp_err", 16'(rsp_err), 16'd1);
        check("tmo_rsp_rdata", rsp_rdata, 16'h0);
        check("tmo_idle", 16'({PSEL0, PENABLE}), 16'b00);
`else
        for (int i = 0; i < 100; i++) begin
            nxt();
            check("stuck_access", 16'({PSEL0, PENABLE, rsp_valid}), 16'b110);
        end
        PRESET = 1;
        nxt();
        PRESET = 0;
        nxt();
`endif

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            PRESET = ($urandom_range(0, 199) == 0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom);
            cmd_addr = 1'($urandom);
            cmd_wdata = 16'($urandom);
            cmd_strb = 2'($urandom);
            cmd_prot = 3'($urandom);
            PREADY = ($urandom_range(0, 9) < 6);
            PSLVERR = ($urandom_range(0, 3) == 0);
            PRDATA = 16'($urandom);
            nxt();
        end
        PRESET = 0; cmd_valid = 0; PREADY = 1;
        repeat (5) nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
